// File: rtl/apb_master_pkg.sv
// Shared types and helpers for the APB requester: FSM state encoding, a
// constant-function clog2, and response codes used when classifying results.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam logic [1:0] RSP_OK      = 2'd0;
  localparam logic [1:0] RSP_SLVERR  = 2'd1;
  localparam logic [1:0] RSP_DECERR  = 2'd2;
  localparam logic [1:0] RSP_TIMEOUT = 2'd3;

endpackage

// File: rtl/apb_master_mux_if.sv
// Command/response handshake plus the APB bus of the requester in one bundle.
// master = the requester's view, slave = the environment (CPU side + peripherals).
interface apb_master_mux_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
);
  localparam int STRB_W = DATA_W / 8;

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_write;
  logic [ADDR_W-1:0]         cmd_addr;
  logic [DATA_W-1:0]         cmd_wdata;
  logic [STRB_W-1:0]         cmd_strb;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic [NUM_SLV-1:0]        PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_W-1:0]         PADDR;
  logic [DATA_W-1:0]         PWDATA;
  logic [STRB_W-1:0]         PSTRB;
  logic [NUM_SLV*DATA_W-1:0] PRDATA;
  logic [NUM_SLV-1:0]        PREADY;
  logic [NUM_SLV-1:0]        PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );
endinterface

// File: rtl/apb_slave_decode.sv
// Combinational slave-index decode with range flag, and per-slave return-path mux.
// Zero latency; no state, no backpressure of its own.
module apb_slave_decode #(
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_W   = 2
) (
  input  logic [SEL_W-1:0]          slv_field,
  output logic [SEL_W-1:0]          dec_idx,
  output logic                      dec_ok,
  input  logic [SEL_W-1:0]          sel_idx,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr,
  output logic [DATA_W-1:0]         sel_rdata,
  output logic                      sel_ready,
  output logic                      sel_err
);

  assign dec_idx = slv_field;
  assign dec_ok  = int'(slv_field) < NUM_SLV;

  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel_idx == SEL_W'(i)) begin
        sel_rdata = prdata[i*DATA_W +: DATA_W];
        sel_ready = pready[i];
        sel_err   = pslverr[i];
      end
    end
  end

endmodule

// File: rtl/apb_master_mux.sv
// APB4 requester to NUM_SLV decoded slaves; response 3 cycles after command, +1 per wait
// state; one command in flight, response held until rsp_ready. APB_MASTER_MUX_TIMEOUT_EN adds an ACCESS timeout.
module apb_master_mux
  import apb_master_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int NUM_SLV   = 4,
  parameter int SLV_SHIFT = 12,
  parameter int TIMEOUT   = 255
) (
  input  logic            PCLK,
  input  logic            PRESET,
  apb_master_mux_if.master bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SEL_W  = (clog2(NUM_SLV) < 1) ? 1 : clog2(NUM_SLV);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } req_t;

  state_t            state, state_nxt;
  req_t              req;
  logic [SEL_W-1:0]  idx;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_nxt;
  logic              rsp_err_q, rsp_err_nxt;
  logic              ld_req, ld_rsp;
  logic [SEL_W-1:0]  dec_idx;
  logic              dec_ok;
  logic [DATA_W-1:0] sel_rdata;
  logic              sel_ready, sel_err;

  apb_slave_decode #(
    .DATA_W (DATA_W),
    .NUM_SLV(NUM_SLV),
    .SEL_W  (SEL_W)
  ) u_dec (
    .slv_field(bus.cmd_addr[SLV_SHIFT +: SEL_W]),
    .dec_idx  (dec_idx),
    .dec_ok   (dec_ok),
    .sel_idx  (idx),
    .prdata   (bus.PRDATA),
    .pready   (bus.PREADY),
    .pslverr  (bus.PSLVERR),
    .sel_rdata(sel_rdata),
    .sel_ready(sel_ready),
    .sel_err  (sel_err)
  );

`ifdef APB_MASTER_MUX_TIMEOUT_EN
  localparam int CNT_RAW = clog2(TIMEOUT + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);

  logic [CNT_W-1:0] wait_cnt;
  logic             cnt_clr, cnt_inc;
  logic             timed_out;

  // Fires on the TIMEOUT-th consecutive low-PREADY ACCESS cycle.
  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET)       wait_cnt <= '0;
    else if (cnt_clr) wait_cnt <= '0;
    else if (cnt_inc) wait_cnt <= wait_cnt + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_comb begin
    state_nxt     = state;
    ld_req        = 1'b0;
    ld_rsp        = 1'b0;
    rsp_err_nxt   = 1'b0;
    rsp_rdata_nxt = '0;
`ifdef APB_MASTER_MUX_TIMEOUT_EN
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          ld_req = 1'b1;
          if (dec_ok) begin
            state_nxt = SETUP;
          end else begin
            state_nxt   = RESP;
            ld_rsp      = 1'b1;
            rsp_err_nxt = 1'b1;
          end
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
`ifdef APB_MASTER_MUX_TIMEOUT_EN
        cnt_clr   = 1'b1;
`endif
      end
      ACCESS: begin
        if (sel_ready) begin
          state_nxt     = RESP;
          ld_rsp        = 1'b1;
          rsp_err_nxt   = sel_err;
          rsp_rdata_nxt = (!req.write && !sel_err) ? sel_rdata : '0;
        end
`ifdef APB_MASTER_MUX_TIMEOUT_EN
        else if (timed_out) begin
          state_nxt   = RESP;
          ld_rsp      = 1'b1;
          rsp_err_nxt = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
`endif
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      req         <= '0;
      idx         <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ld_req) begin
        req.write <= bus.cmd_write;
        req.addr  <= bus.cmd_addr;
        req.wdata <= bus.cmd_wdata;
        req.strb  <= bus.cmd_write ? bus.cmd_strb : '0;
        idx       <= dec_idx;
      end
      if (ld_rsp) begin
        rsp_rdata_q <= rsp_rdata_nxt;
        rsp_err_q   <= rsp_err_nxt;
      end
    end
  end

  always_comb begin
    bus.PSEL = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      bus.PSEL[i] = ((state == SETUP) || (state == ACCESS)) && (idx == SEL_W'(i));
    end
  end

  assign bus.PENABLE   = (state == ACCESS);
  assign bus.PWRITE    = req.write;
  assign bus.PADDR     = req.addr;
  assign bus.PWDATA    = req.wdata;
  assign bus.PSTRB     = req.strb;
  assign bus.cmd_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_mux.sv
// Directed bench for apb_master_mux: scoreboarded responses, per-cycle APB phase checks.
module tb_apb_master_mux;
  import apb_master_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;

  typedef struct {
    logic [1:0]  code;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_master_mux_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS)) bus ();
  apb_master_mux_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(3))  bus3 ();

  apb_master_mux #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .SLV_SHIFT(12), .TIMEOUT(4)
  ) u_dut (
    .PCLK  (clk),
    .PRESET(rst),
    .bus   (bus)
  );

  apb_master_mux #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(3), .SLV_SHIFT(12), .TIMEOUT(4)
  ) u_dut3 (
    .PCLK  (clk),
    .PRESET(rst),
    .bus   (bus3)
  );

  exp_t sb[$];
  int   checks   = 0;
  int   fails    = 0;
  int   cyc      = 0;
  int   acc_cnt  = 0;
  int   wait_cfg = 0;
  logic err_cfg  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then play the slaves: the selected one answers after
  // wait_cfg ACCESS cycles; unselected ones assert PREADY/PSLVERR as noise.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NS; i++) begin
      if (bus.PSEL[i] && bus.PENABLE) begin
        bus.PREADY[i]  = (acc_cnt >= wait_cfg);
        bus.PSLVERR[i] = (acc_cnt >= wait_cfg) && err_cfg;
      end else begin
        bus.PREADY[i]  = 1'b1;
        bus.PSLVERR[i] = 1'b1;
      end
    end
    if (bus.PENABLE) acc_cnt++;
    else acc_cnt = 0;
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [1:0] code,
                      input logic [31:0] rd, input bit exp_rsp);
    exp_t e;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_strb  = s;
    if (exp_rsp) begin
      e.code  = code;
      e.rdata = rd;
      sb.push_back(e);
    end
    chk("cmd_ready_idle", {63'd0, bus.cmd_ready}, 64'd1);
    cyc = 0;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int exp_cyc);
    exp_t e;
    for (int k = 0; k < 300 && bus.rsp_valid !== 1'b1; k++) step();
    chk({tag, "_vld"}, {63'd0, bus.rsp_valid}, 64'd1);
    chk({tag, "_cyc"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_psel"}, 64'(bus.PSEL), 64'd0);
    if (sb.size() == 0) begin
      checks++;
      fails++;
      $error("FAIL %s_sb: got empty queue expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_err"}, {63'd0, bus.rsp_err}, {63'd0, (e.code != RSP_OK)});
      chk({tag, "_rdata"}, 64'(bus.rsp_rdata), 64'(e.rdata));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_write  = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_wdata  = '0;
    bus.cmd_strb   = '0;
    bus.rsp_ready  = 1'b1;
    bus.PRDATA     = '0;
    bus.PREADY     = '0;
    bus.PSLVERR    = '0;
    bus3.cmd_valid = 1'b0;
    bus3.cmd_write = 1'b0;
    bus3.cmd_addr  = '0;
    bus3.cmd_wdata = '0;
    bus3.cmd_strb  = '0;
    bus3.rsp_ready = 1'b1;
    bus3.PRDATA    = '1;
    bus3.PREADY    = '1;
    bus3.PSLVERR   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_psel",    64'(bus.PSEL), 64'd0);
    chk("rst_penable", {63'd0, bus.PENABLE}, 64'd0);
    chk("rst_pwrite",  {63'd0, bus.PWRITE}, 64'd0);
    chk("rst_paddr",   64'(bus.PADDR), 64'd0);
    chk("rst_pwdata",  64'(bus.PWDATA), 64'd0);
    chk("rst_pstrb",   64'(bus.PSTRB), 64'd0);
    chk("rst_rsp_vld", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst_rdata",   64'(bus.rsp_rdata), 64'd0);
    chk("rst_err",     {63'd0, bus.rsp_err}, 64'd0);
    chk("rst_cmd_rdy", {63'd0, bus.cmd_ready}, 64'd1);

    // Write to slave 1, zero wait states
    bus.PRDATA = {32'h3333_0000, 32'h2222_0000, 32'h1111_5555, 32'h0000_0000};
    wait_cfg = 0;
    send(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, RSP_OK, 32'h0, 1'b1);
    chk("wr_c1_psel",    64'(bus.PSEL), 64'h2);
    chk("wr_c1_penable", {63'd0, bus.PENABLE}, 64'd0);
    chk("wr_c1_pwrite",  {63'd0, bus.PWRITE}, 64'd1);
    chk("wr_c1_paddr",   64'(bus.PADDR), 64'h1004);
    chk("wr_c1_pwdata",  64'(bus.PWDATA), 64'hDEAD_BEEF);
    chk("wr_c1_pstrb",   64'(bus.PSTRB), 64'hF);
    chk("wr_c1_cmd_rdy", {63'd0, bus.cmd_ready}, 64'd0);
    step();
    chk("wr_c2_psel",    64'(bus.PSEL), 64'h2);
    chk("wr_c2_penable", {63'd0, bus.PENABLE}, 64'd1);
    chk("wr_c2_rsp_vld", {63'd0, bus.rsp_valid}, 64'd0);
    wait_rsp("wr", 3);
    step();

    // Read from slave 3 with three wait states while other slaves shout ready
    bus.PRDATA[3*DW +: DW] = 32'h0000_0309;
    wait_cfg = 3;
    send(1'b0, 32'h0000_3008, 32'hFFFF_FFFF, 4'hF, RSP_OK, 32'h0000_0309, 1'b1);
    chk("rd3_psel",   64'(bus.PSEL), 64'h8);
    chk("rd3_pstrb",  64'(bus.PSTRB), 64'h0);
    chk("rd3_pwrite", {63'd0, bus.PWRITE}, 64'd0);
    chk("rd3_paddr",  64'(bus.PADDR), 64'h3008);
    wait_rsp("rd3", 6);
    step();

    // Slave error on slave 2 suppresses read data
    bus.PRDATA[2*DW +: DW] = 32'h0000_1234;
    wait_cfg = 0;
    err_cfg  = 1'b1;
    send(1'b0, 32'h0000_2010, 32'h0, 4'h0, RSP_SLVERR, 32'h0, 1'b1);
    wait_rsp("slverr", 3);
    step();
    err_cfg = 1'b0;

    // Clean read from slave 2; unselected slaves keep PSLVERR high
    wait_cfg = 1;
    send(1'b0, 32'h0000_2014, 32'h0, 4'h0, RSP_OK, 32'h0000_1234, 1'b1);
    wait_rsp("rd2", 4);
    step();

    // Decode error with three slaves: no PSEL, response in cycle 1
    bus3.cmd_valid = 1'b1;
    bus3.cmd_write = 1'b0;
    bus3.cmd_addr  = 32'h0000_3000;
    chk("dec_cmd_rdy", {63'd0, bus3.cmd_ready}, 64'd1);
    step();
    bus3.cmd_valid = 1'b0;
    chk("dec_rsp_vld", {63'd0, bus3.rsp_valid}, 64'd1);
    chk("dec_err",     {63'd0, bus3.rsp_err}, 64'd1);
    chk("dec_rdata",   64'(bus3.rsp_rdata), 64'd0);
    chk("dec_psel",    64'(bus3.PSEL), 64'd0);
    step();
    chk("dec_idle_rdy", {63'd0, bus3.cmd_ready}, 64'd1);
    chk("dec_idle_vld", {63'd0, bus3.rsp_valid}, 64'd0);

    // Response backpressure: held stable while the slave data changes
    bus.rsp_ready = 1'b0;
    bus.PRDATA[0 +: DW] = 32'hA5A5_0000;
    wait_cfg = 0;
    send(1'b0, 32'h0000_0040, 32'h0, 4'h0, RSP_OK, 32'hA5A5_0000, 1'b1);
    wait_rsp("bp", 3);
    bus.PRDATA[0 +: DW] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_vld",   {63'd0, bus.rsp_valid}, 64'd1);
      chk("bp_hold_rdata", 64'(bus.rsp_rdata), 64'hA5A5_0000);
      chk("bp_hold_cmdr",  {63'd0, bus.cmd_ready}, 64'd0);
    end
    bus.rsp_ready = 1'b1;
    step();
    chk("bp_done_vld", {63'd0, bus.rsp_valid}, 64'd0);
    chk("bp_done_rdy", {63'd0, bus.cmd_ready}, 64'd1);

    // Reset in the middle of ACCESS aborts silently
    wait_cfg = 1000;
    send(1'b1, 32'h0000_2000, 32'h0000_0055, 4'h1, RSP_OK, 32'h0, 1'b0);
    step();
    chk("ab_penable", {63'd0, bus.PENABLE}, 64'd1);
    chk("ab_psel",    64'(bus.PSEL), 64'h4);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ab_rst_psel",    64'(bus.PSEL), 64'd0);
    chk("ab_rst_penable", {63'd0, bus.PENABLE}, 64'd0);
    chk("ab_rst_paddr",   64'(bus.PADDR), 64'd0);
    chk("ab_rst_pwdata",  64'(bus.PWDATA), 64'd0);
    chk("ab_rst_vld",     {63'd0, bus.rsp_valid}, 64'd0);
    chk("ab_rst_cmdr",    {63'd0, bus.cmd_ready}, 64'd1);
    repeat (3) step();
    chk("ab_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);

    // Slave that never answers
`ifdef APB_MASTER_MUX_TIMEOUT_EN
    send(1'b0, 32'h0000_1000, 32'h0, 4'h0, RSP_TIMEOUT, 32'h0, 1'b1);
    repeat (4) step();
    chk("tmo_c5_psel", 64'(bus.PSEL), 64'h2);
    wait_rsp("tmo", 6);
    step();
`else
    send(1'b0, 32'h0000_1000, 32'h0, 4'h0, RSP_OK, 32'h0, 1'b0);
    repeat (101) step();
    chk("hang_psel",    64'(bus.PSEL), 64'h2);
    chk("hang_penable", {63'd0, bus.PENABLE}, 64'd1);
    chk("hang_vld",     {63'd0, bus.rsp_valid}, 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
`endif

    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/apb_master_mux.md
Name: apb_master_mux

Overview:
- Parametrised APB4 requester: the next generation of the team's single-slave APB master.
- Accepts one command at a time on a valid/ready command port.
- Runs the full IDLE → SETUP → ACCESS protocol towards NUM_SLV slaves, with address-decoded PSEL.
- Returns read data and error status on a held valid/ready response port.
- Sits between the CPU-side register bus and the peripheral slaves.

Parameters:
- ADDR_W, 32, address width of command and PADDR.
- DATA_W, 32, data width; must be 8, 16 or 32.
- NUM_SLV, 4, number of slaves; 1..16.
- SLV_SHIFT, 12, slave index = cmd_addr[SLV_SHIFT +: SEL_W], where SEL_W = clog2(NUM_SLV), minimum 1.
- TIMEOUT, 255, maximum ACCESS wait cycles; only used with the optional feature.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready are both high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready are both high.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  slave error, decode error or timeout.
- PSEL  out  NUM_SLV  one-hot slave select.
- PENABLE  out  1  ACCESS phase marker.
- PWRITE  out  1  transfer direction.
- PADDR  out  ADDR_W  transfer address.
- PWDATA  out  DATA_W  write data.
- PSTRB  out  DATA_W/8  byte strobes.
- PRDATA  in  NUM_SLV*DATA_W  per-slave read data; slave i occupies [i*DATA_W +: DATA_W].
- PREADY  in  NUM_SLV  per-slave ready.
- PSLVERR  in  NUM_SLV  per-slave error.

Behaviour:
- Reset (PRESET=1 at a PCLK edge) forces the state to IDLE and clears everything else.
  - Zero after reset: PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err.
  - cmd_ready = 1 in the first cycle after reset.
  - Reset mid-transfer aborts it: no response is produced, and PSEL drops in the next cycle.
- States are IDLE, SETUP, ACCESS and RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, register PWRITE, PADDR, PWDATA and PSTRB. PSTRB is forced to 0 for reads.
  - Decode the slave index.
    - Index < NUM_SLV: go to SETUP.
    - Index ≥ NUM_SLV: go to RESP with rsp_err=1 and rsp_rdata=0. No PSEL is asserted.
- SETUP:
  - PSEL[idx]=1, PENABLE=0, cmd_ready=0.
  - Unconditionally go to ACCESS on the next cycle.
- ACCESS:
  - PSEL[idx]=1, PENABLE=1.
  - PADDR, PWDATA, PWRITE and PSTRB stay stable.
  - Stay in ACCESS while PREADY[idx]=0.
  - When PREADY[idx]=1, in the same cycle:
    - capture rsp_err = PSLVERR[idx];
    - capture rsp_rdata = PRDATA slice idx, for reads with no error only, else 0;
    - go to RESP.
  - PREADY and PSLVERR from non-selected slaves are ignored.
- RESP:
  - PSEL=0, PENABLE=0, rsp_valid=1.
  - rsp_rdata and rsp_err are held until rsp_ready; then go to IDLE.
  - rsp_ready already high on entry gives a single-cycle RESP.
- Latency, counting the command handshake as cycle 0:
  - SETUP in cycle 1, first ACCESS in cycle 2.
  - rsp_valid in cycle 3 with zero wait states; each wait state adds one cycle.
  - Minimum command-to-command spacing is 4 cycles.
- PADDR, PWDATA, PWRITE and PSTRB keep their last values outside transfers; PSEL and PENABLE are 0.
- Exactly one PSEL bit is high at any time, or none.
- cmd_valid is never sampled outside IDLE.

Optional Feature:
- Macro APB_MASTER_MUX_TIMEOUT_EN.
- Defined:
  - An 8..16-bit wait counter, sized to clog2(TIMEOUT+1), is cleared on entry to ACCESS and increments each ACCESS cycle with PREADY[idx]=0.
  - When it reaches TIMEOUT, abort: PSEL=0, PENABLE=0 in the next cycle; go to RESP with rsp_err=1 and rsp_rdata=0.
  - A late PREADY is ignored.
- Undefined: no counter; ACCESS waits indefinitely; the TIMEOUT parameter is unused.

Decomposition:
- Package apb_master_pkg holds:
  - the state enum type (IDLE, SETUP, ACCESS, RESP; 2 bits);
  - the clog2 helper function;
  - a response-code localparam set (OK, SLVERR, DECERR, TIMEOUT) for use by benches.
- One natural sub-module, apb_slave_decode:
  - combinational address-to-index decode plus an in-range flag;
  - also performs the per-slave PRDATA/PREADY/PSLVERR mux from idx.

Test Plan:
- Write, zero wait: cmd write, addr 0x0000_1004, data 0xDEAD_BEEF, strb 0xF; slave1 PREADY=1.
  - Required: PSEL=4'b0010 in cycles 1-2, PENABLE only in cycle 2; PWDATA=0xDEADBEEF; rsp_valid in cycle 3 with err=0 and rdata=0.
- Read, 3 wait states: read addr 0x3008; slave3 returns PRDATA=0x0000_0309 after 3 low-PREADY cycles.
  - Required: PSTRB=0; rsp_rdata=0x309 in cycle 6.
- Slave error: read from slave 2 with PSLVERR=1 and PRDATA=0x1234 at PREADY.
  - Required: rsp_err=1, rsp_rdata=0.
- Decode error: NUM_SLV=3, addr 0x3000.
  - Required: PSEL stays 0; rsp_valid in cycle 1 with err=1.
- Backpressure and reset:
  - hold rsp_ready=0 for 5 cycles: response stable, cmd_ready=0;
  - then PRESET mid-ACCESS of the next transfer: outputs zero the following cycle, no rsp_valid.
- Timeout (macro defined, TIMEOUT=4): PREADY held 0.
  - Required: PSEL drops after 4 wait cycles; rsp_err=1.
  - Macro undefined: still in ACCESS after 100 cycles.
